// File: rtl/sport_dma_arb.sv
// SPORT autobuffer DMA arbiter.
// Four SPORT autobuffer requesters compete for one stolen DM cycle at a time.
// The block also tracks how long each requester waits and keeps a sticky
// starve flag per requester.
// Optional build macro SPORT_ARB_RR_EN changes how winners are picked:
// RX still beats TX, but SP0 and SP1 alternate within each class.
// Without the macro the priority is fixed: SP0 RX > SP1 RX > SP0 TX > SP1 TX.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no grant held; arbitrate on any request
// ARB_WAIT | winner latched, BUS_REQ high, waiting for BUS_GNT
// ACK      | one-cycle ack to the winner
// RECOV    | one-cycle recovery; the just-served requester is ignored
module sport_dma_arb #(
    parameter int STARVE_LIM = 15
) (
    input  logic       DSPCLK,
    input  logic       RSTn,
    input  logic       SP0_TSreq,
    input  logic       SP0_RSreq,
    input  logic       SP1_TSreq,
    input  logic       SP1_RSreq,
    input  logic       BUS_GNT,
    input  logic       CLR_STARVE,
    output logic       SP0_TSack,
    output logic       SP0_RSack,
    output logic       SP1_TSack,
    output logic       SP1_RSack,
    output logic       BUS_REQ,
    output logic [1:0] GRANT_ID,
    output logic       GRANT_VLD,
    output logic [3:0] STARVE
);

    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM    = CW'(STARVE_LIM);
    localparam logic [CW-1:0] LIM_M1 = CW'(STARVE_LIM - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARB_WAIT = 2'd1,
        ACK      = 2'd2,
        RECOV    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    req;
    logic [1:0]    winner;
    logic [3:0]    ack_q;
    logic [3:0]    ack_nxt;
    logic          bus_req_q;
    logic          bus_req_nxt;
    logic [1:0]    gid_q;
    logic [1:0]    gid_nxt;
    logic          vld_q;
    logic          vld_nxt;
    logic [CW-1:0] cnt [4];
    logic [3:0]    inc;
    logic [3:0]    hit;
    logic [3:0]    starve_q;

    // Request vector ordered the same way as GRANT_ID.
    assign req = {SP1_TSreq, SP0_TSreq, SP1_RSreq, SP0_RSreq};

`ifdef SPORT_ARB_RR_EN
    logic rx_last;
    logic tx_last;

    // Class priority RX over TX; within a class favour the side not served last.
    always_comb begin
        winner = 2'd0;
        if (req[0] && req[1]) begin
            winner = rx_last ? 2'd0 : 2'd1;
        end else if (req[0]) begin
            winner = 2'd0;
        end else if (req[1]) begin
            winner = 2'd1;
        end else if (req[2] && req[3]) begin
            winner = tx_last ? 2'd2 : 2'd3;
        end else if (req[2]) begin
            winner = 2'd2;
        end else if (req[3]) begin
            winner = 2'd3;
        end
    end

    // Last-served pointers move only when an ack is actually issued, never on abort.
    always_ff @(posedge DSPCLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_last <= 1'b1;
            tx_last <= 1'b1;
        end else if (state == ACK) begin
            if (!gid_q[1]) begin
                rx_last <= gid_q[0];
            end else begin
                tx_last <= gid_q[0];
            end
        end
    end
`else
    // Fixed priority: lowest GRANT_ID wins.
    always_comb begin
        winner = 2'd0;
        if (req[0]) begin
            winner = 2'd0;
        end else if (req[1]) begin
            winner = 2'd1;
        end else if (req[2]) begin
            winner = 2'd2;
        end else if (req[3]) begin
            winner = 2'd3;
        end
    end
`endif

    // FSM state and registered outputs.
    always_ff @(posedge DSPCLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            ack_q     <= 4'b0000;
            bus_req_q <= 1'b0;
            gid_q     <= 2'd0;
            vld_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            ack_q     <= ack_nxt;
            bus_req_q <= bus_req_nxt;
            gid_q     <= gid_nxt;
            vld_q     <= vld_nxt;
        end
    end

    // Next state and next output values; BUS_GNT only matters in ARB_WAIT.
    always_comb begin
        state_nxt   = state;
        ack_nxt     = 4'b0000;
        bus_req_nxt = 1'b0;
        gid_nxt     = gid_q;
        vld_nxt     = vld_q;
        case (state)
            IDLE: begin
                vld_nxt = 1'b0;
                if (|req) begin
                    gid_nxt     = winner;
                    vld_nxt     = 1'b1;
                    bus_req_nxt = 1'b1;
                    state_nxt   = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (!req[gid_q]) begin
                    vld_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (BUS_GNT) begin
                    ack_nxt   = 4'b0001 << gid_q;
                    state_nxt = ACK;
                end else begin
                    bus_req_nxt = 1'b1;
                end
            end
            ACK: begin
                state_nxt = RECOV;
            end
            RECOV: begin
                vld_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                vld_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // A requester is waiting while it requests and is not currently acked;
    // a starve event is the single cycle its counter reaches the limit.
    always_comb begin
        inc = 4'b0000;
        hit = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            inc[i] = req[i] & ~ack_q[i];
            hit[i] = inc[i] & (cnt[i] == LIM_M1);
        end
    end

    // Saturating wait counters and sticky starve flags; a new set beats a clear.
    always_ff @(posedge DSPCLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            starve_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!inc[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != LIM) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            starve_q <= (starve_q & {4{~CLR_STARVE}}) | hit;
        end
    end

    assign SP0_RSack = ack_q[0];
    assign SP1_RSack = ack_q[1];
    assign SP0_TSack = ack_q[2];
    assign SP1_TSack = ack_q[3];
    assign BUS_REQ   = bus_req_q;
    assign GRANT_ID  = gid_q;
    assign GRANT_VLD = vld_q;
    assign STARVE    = starve_q;

endmodule

// File: tb/tb_sport_dma_arb.sv
// Directed bench for sport_dma_arb (default fixed-priority build, STARVE_LIM=15).
module tb_sport_dma_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       gnt;
    logic       clr;
    wire  [3:0] ack;
    wire        bus_req;
    wire  [1:0] gid;
    wire        vld;
    wire  [3:0] starve;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sport_dma_arb #(.STARVE_LIM(15)) dut (
        .DSPCLK     (clk),
        .RSTn       (rst_n),
        .SP0_TSreq  (req[2]),
        .SP0_RSreq  (req[0]),
        .SP1_TSreq  (req[3]),
        .SP1_RSreq  (req[1]),
        .BUS_GNT    (gnt),
        .CLR_STARVE (clr),
        .SP0_TSack  (ack[2]),
        .SP0_RSack  (ack[0]),
        .SP1_TSack  (ack[3]),
        .SP1_RSack  (ack[1]),
        .BUS_REQ    (bus_req),
        .GRANT_ID   (gid),
        .GRANT_VLD  (vld),
        .STARVE     (starve)
    );

    // Record: inputs applied before an edge, outputs expected just after it.
    // exp = {bus_req, ack[3:0], grant_id[1:0], grant_vld, starve[3:0]}
    typedef struct packed {
        logic [3:0]  req;
        logic        gnt;
        logic        clr;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(logic [3:0] r, logic g, logic b, logic [3:0] a,
                                logic [1:0] id, logic v);
        vec_t t;
        t.req = r;
        t.gnt = g;
        t.clr = 1'b0;
        t.exp = {b, a, id, v, 4'b0000};
        return t;
    endfunction

    function automatic logic [11:0] outs();
        return {bus_req, ack, gid, vld, starve};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        gnt   = 1'b0;
        clr   = 1'b0;
        #1;
        check("reset_state", 32'(outs()), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // At most one ack may be high in any cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            tests++;
            if (!$onehot0(ack)) begin
                fails++;
                $display("FAIL onehot_ack: got %b, expected at most one bit set", ack);
            end
        end
    end

    initial begin
        int cyc;
        bit got;

        rst_n = 1'b1;
        req   = 4'b0000;
        gnt   = 1'b0;
        clr   = 1'b0;

        //          req      gnt  breq ack      id     vld
        vecs[0]  = mk(4'b1000, 1'b1, 1'b1, 4'b0000, 2'd3, 1'b1);
        vecs[1]  = mk(4'b1000, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1);
        vecs[2]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1);
        vecs[3]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0);
        vecs[4]  = mk(4'b0110, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b1);
        vecs[5]  = mk(4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
        vecs[6]  = mk(4'b0100, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1);
        vecs[7]  = mk(4'b0100, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0);
        vecs[8]  = mk(4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b1);
        vecs[9]  = mk(4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1);
        vecs[10] = mk(4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1);
        vecs[11] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1);
        vecs[12] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0);
        vecs[13] = mk(4'b0001, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b1);
        vecs[14] = mk(4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1);
        vecs[15] = mk(4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1);
        vecs[16] = mk(4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
        vecs[17] = mk(4'b0001, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b1);
        vecs[18] = mk(4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1);
        vecs[19] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1);
        vecs[20] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);

        #2;
        do_reset();

        // Table: single SP1 TX request, mixed requests, grant withheld, back-to-back.
        for (int i = 0; i < 21; i++) begin
            req = vecs[i].req;
            gnt = vecs[i].gnt;
            clr = vecs[i].clr;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // All four held; each requester drops after its ack.
        do_reset();
        req = 4'b1111;
        gnt = 1'b1;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick();
                cyc++;
                if (ack != 4'b0000) got = 1'b1;
            end
            check($sformatf("prio_ack%0d", k), 32'(ack), 32'd1 << k);
            check($sformatf("prio_id%0d", k), 32'(gid), 32'(k));
            check($sformatf("prio_cycle%0d", k), 32'(cyc), 32'(2 + 4 * k));
            req[k] = 1'b0;
        end

        // Abort: winner drops its request before BUS_GNT.
        do_reset();
        req = 4'b0001;
        gnt = 1'b0;
        tick();
        check("abort_enter", 32'({bus_req, ack, gid, vld}), 32'({1'b1, 4'b0000, 2'd0, 1'b1}));
        tick();
        tick();
        check("abort_wait", 32'({bus_req, ack, vld}), 32'({1'b1, 4'b0000, 1'b1}));
        req = 4'b0000;
        tick();
        check("abort_idle", 32'({bus_req, ack, vld}), 32'h0);
        gnt = 1'b1;
        tick();
        check("abort_no_ack", 32'({bus_req, ack, vld}), 32'h0);

        // Starvation of SP1 TX while SP0 RX keeps winning, then clear.
        do_reset();
        req = 4'b1001;
        gnt = 1'b1;
        for (int c = 0; c < 14; c++) tick();
        check("starve_before", 32'(starve), 32'h0);
        tick();
        check("starve_set", 32'(starve), 32'h8);
        tick();
        tick();
        check("starve_sticky", 32'(starve), 32'h8);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("starve_clr", 32'(starve), 32'h0);
        tick();
        check("starve_stay_clr", 32'(starve), 32'h0);

        // Clear in the same cycle a counter saturates: set wins.
        do_reset();
        req = 4'b1000;
        gnt = 1'b0;
        for (int c = 0; c < 14; c++) tick();
        clr = 1'b1;
        tick();
        check("clr_race_set", 32'(starve), 32'h8);
        tick();
        check("clr_race_next", 32'(starve), 32'h0);
        clr = 1'b0;

        // Reset while BUS_REQ is high in ARB_WAIT.
        do_reset();
        req = 4'b1000;
        gnt = 1'b0;
        tick();
        check("rst_wait_pre", 32'(bus_req), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_wait_async", 32'({bus_req, ack, vld}), 32'h0);

        // Reset during the ack cycle, then release with requests low.
        do_reset();
        req = 4'b1000;
        gnt = 1'b1;
        tick();
        tick();
        check("rst_ack_pre", 32'(ack), 32'h8);
        rst_n = 1'b0;
        #1;
        check("rst_ack_async", 32'({bus_req, ack, vld}), 32'h0);
        req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("rst_release%0d", c), 32'(outs()), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sport_dma_arb.md
SPORT_DMA_ARB -- requirements
Module: sport_dma_arb

Interface
REQ-001 The block SHALL run on one clock with an asynchronous, active-low reset: DSPCLK input 1, the clock; RSTn input 1, async active-low reset.
REQ-002 The block SHALL have parameter STARVE_LIM, default 15, the wait-cycle limit that flags a starved requester (range 1..255).
REQ-003 The block SHALL have input SP0_TSreq, 1 bit: SPORT0 transmit autobuffer request (level).
REQ-004 The block SHALL have input SP0_RSreq, 1 bit: SPORT0 receive autobuffer request (level).
REQ-005 The block SHALL have input SP1_TSreq, 1 bit: SPORT1 transmit autobuffer request (level).
REQ-006 The block SHALL have input SP1_RSreq, 1 bit: SPORT1 receive autobuffer request (level).
REQ-007 The block SHALL have input BUS_GNT, 1 bit: core grants one stolen DM cycle.
REQ-008 The block SHALL have input CLR_STARVE, 1 bit: clears the sticky starve flags.
REQ-009 The block SHALL have outputs SP0_TSack, SP0_RSack, SP1_TSack and SP1_RSack, 1 bit each: single-cycle acknowledges.
REQ-010 The block SHALL have output BUS_REQ, 1 bit: request for a DM cycle.
REQ-011 The block SHALL have outputs GRANT_ID (2 bits: 0=SP0 RX, 1=SP1 RX, 2=SP0 TX, 3=SP1 TX) and GRANT_VLD (1 bit).
REQ-012 The block SHALL have output STARVE, 4 bits: sticky per-requester starve flags, indexed as GRANT_ID.

Function
REQ-013 All outputs SHALL be registered and driven from the FSM states IDLE, ARB_WAIT, ACK and RECOV.
REQ-014 IDLE: with any request high, the block SHALL latch the winner into GRANT_ID, set GRANT_VLD=1 and go to ARB_WAIT; with no request high it SHALL stay in IDLE.
REQ-015 ARB_WAIT: BUS_REQ SHALL be 1; BUS_GNT=1 with the winner still requesting SHALL move the FSM to ACK.
REQ-016 ARB_WAIT: a winner request that drops before BUS_GNT SHALL return the FSM to IDLE with BUS_REQ=0, no ack and GRANT_VLD=0 (abort).
REQ-017 ACK: the winner's ack SHALL be 1 for exactly one cycle, BUS_REQ SHALL be 0, and the FSM SHALL go to RECOV.
REQ-018 RECOV: the block SHALL spend one cycle there, ignore the just-served requester, clear GRANT_VLD and return to IDLE.
REQ-019 Minimum latency SHALL be: request high at edge N gives ack high after edge N+2 when BUS_GNT is held 1; back-to-back services SHALL be 4 cycles apart.
REQ-020 A request still high after RECOV SHALL be a new request.
REQ-021 At most one ack SHALL be high in any cycle.
REQ-022 Default priority SHALL be fixed: SP0 RX > SP1 RX > SP0 TX > SP1 TX.
REQ-023 Each requester SHALL have a saturating wait counter of width ceil(log2(STARVE_LIM+1)) that increments while its request is high and it is not being acked.
REQ-024 A wait counter SHALL clear on that requester's ack or on its request being low.
REQ-025 When a wait counter reaches STARVE_LIM, the matching STARVE bit SHALL set sticky and the counter SHALL hold.
REQ-026 CLR_STARVE=1 SHALL clear all STARVE bits; a set in the same cycle SHALL win.
REQ-027 BUS_GNT SHALL be ignored outside ARB_WAIT.

Reset
REQ-028 RSTn low SHALL immediately force: FSM=IDLE; BUS_REQ, all acks, GRANT_VLD = 0; GRANT_ID = 0; counters and STARVE = 0.
REQ-029 Reset mid-ARB_WAIT or mid-ACK SHALL drop BUS_REQ and the ack asynchronously; no ack SHALL be issued after release until a new arbitration.
REQ-030 After reset deassertion the block SHALL arbitrate from IDLE on the first DSPCLK edge.

Configuration
REQ-031 With SPORT_ARB_RR_EN defined, RX requests SHALL still beat TX requests, but within each class SP0/SP1 SHALL alternate by round-robin.
REQ-032 Under SPORT_ARB_RR_EN, each class SHALL keep a 1-bit last-served pointer, reset to SP1, that updates only on ACK (not on abort).
REQ-033 Without SPORT_ARB_RR_EN, the fixed priority of REQ-022 SHALL apply and no pointer SHALL exist.

Verification
REQ-034 Bench SHALL check: SP1_TSreq=1, BUS_GNT=1 constant -> BUS_REQ after edge 1, SP1_TSack=1 after edge 2 for one cycle, GRANT_ID=3.
REQ-035 Bench SHALL check: all four requests held, BUS_GNT=1 -> acks in order RX0, RX1, TX0, TX1 (fixed) or RX0, RX1, TX0, TX1 with RX0/RX1 alternating thereafter (RR), each 4 cycles apart.
REQ-036 Bench SHALL check: SP0_RSreq=1, BUS_GNT=0 for 3 cycles, then SP0_RSreq=0 -> abort to IDLE, BUS_REQ=0, no ack, RR pointer unchanged.
REQ-037 Bench SHALL check: STARVE_LIM=15, SP1_TSreq held while SP0_RSreq served repeatedly -> STARVE[3]=1 after 15 waiting cycles; CLR_STARVE pulse with no new saturation -> STARVE=0.
REQ-038 Bench SHALL check: RSTn low during ACK cycle -> ack and BUS_REQ drop immediately; after release with requests low, outputs stay 0.
REQ-039 Bench SHALL check: CLR_STARVE=1 in the same cycle a counter saturates -> STARVE bit reads 1.
